log_scheduler: RTL and testbench
================================

// Module: log_scheduler
// PURPOSE
//  Shares one iterative 14-bit log core among N_REQ requesters with round-robin arbitration.
//  Per job: accepts one requester's operand, pulses the core's start, and counts the fixed core latency.
//  It then captures xf/yf and returns the result tagged with the requester id.
//  Sits between client blocks and the log core; the core has no done flag, so this block owns all timing.
// PARAMETERS
//  N_REQ        4   number of requesters (>=2)
//  W            14  operand/result width (matches log core x0/xf/yf)
//  LOG_LATENCY  12  cycles from the log_start cycle until log_xf/log_yf are valid (>=1)
//  IDW          2   requester id width, clog2(N_REQ)
// PORTS
//  clk        in   1         rising-edge clock
//  reset      in   1         synchronous, active-high
//  req        in   N_REQ     level request per requester; held with req_x until ack
//  req_x      in   N_REQ*W   packed operands; requester i at [i*W +: W]
//  ack        out  N_REQ     one-hot, 1-cycle pulse: operand of requester i accepted
//  res_valid  out  1         1-cycle pulse: res_* valid
//  res_id     out  IDW       requester that owns the result
//  res_x      out  W         captured log_xf
//  res_y      out  W         captured log_yf (logarithm)
//  res_err    out  1         operand was zero; no core run; res_x=res_y=0
//  busy       out  1         high in every state except IDLE
//  log_x0     out  W         operand to core; held stable from LAUNCH until next LAUNCH
//  log_start  out  1         1-cycle start pulse to core
//  log_xf     in   W         core x output
//  log_yf     in   W         core y output
// BEHAVIOUR
//  - All outputs are registered. On reset: every output is 0, state=IDLE, rr pointer=0, counter=0.
//  - FSM: IDLE -> LAUNCH -> WAIT -> DONE -> IDLE. Zero-operand path: IDLE -> DONE.
//  - IDLE: if |req, grant g = first set req at or after ptr (wrapping). Latch g and req_x[g].
//    If latched operand != 0, go to LAUNCH; else go to DONE with err flag set.
//  - LAUNCH (1 cycle): ack[g]=1, log_start=1, busy=1, log_x0=operand. cnt loads LOG_LATENCY-1.
//  - WAIT: decrement cnt. At the edge where cnt==0, capture log_xf/log_yf and go to DONE.
//    log_yf is therefore sampled at the end of cycle L+LOG_LATENCY, where L is the log_start cycle.
//  - DONE (1 cycle): res_valid=1, res_id=g. ptr <= (g+1) mod N_REQ. Next state is IDLE.
//  - Zero-operand DONE: ack[g]=1 and res_err=1 in the same cycle. No log_start is issued.
//  - Normal-job latency: req seen in IDLE cycle T gives ack at T+1 and res_valid at T+LOG_LATENCY+2.
//    Normal jobs take LOG_LATENCY+3 cycles each, back to back.
//  - Requester must drop req in the cycle after ack. Otherwise the held req is a new request,
//    re-arbitrated at the next IDLE.
//  - A requester may withdraw req before ack; only req sampled in IDLE counts.
//  - Requests arriving during busy wait; there is no queueing beyond the held req lines.
//  - A requester re-requesting in its own DONE cycle gets lowest priority, because ptr has moved past it.
//  - reset in any state, including mid-WAIT: return to IDLE next edge with all outputs 0.
//    The in-flight core result is discarded and no res_valid is issued.
//  - ptr wraps N_REQ-1 -> 0. With a single active requester, ptr still advances; no starvation.
// STRUCTURE
//  - Shared header log_sched_defs.vh: FSM state encodings (S_IDLE, S_LAUNCH, S_WAIT, S_DONE),
//    default W=14, and a clog2 function.
//  - Sub-module rr_pick: combinational round-robin picker (req, ptr -> one-hot grant, id, any).
//  - The log core is instantiated by the parent, not inside this block.
// TESTING (bench uses a stub core: after LOG_LATENCY cycles, yf = x0 ^ 14'h3FFF and xf = 14'h0200)
//  - Single job: req=4'b0001, req_x[0]=14'b0000_1011100000 (0x2E0).
//    Expect ack=0001 at T+1, one log_start with log_x0=0x2E0, res_valid at T+14.
//    Expect res_id=0, res_y=0x3D1F, res_x=0x200.
//  - Contention: req=4'b1111 held until each ack.
//    Expect res_id order 0,1,2,3 and exactly 4 log_start pulses, 15 cycles apart.
//  - Fairness: after id 1 is served, req=4'b1001. Expect 3 granted before 0.
//  - Zero operand: req=4'b0100, req_x[2]=0.
//    Expect ack=0100, res_valid, res_err=1, res_id=2, res_y=0 in the same cycle; log_start never asserted.
//  - Reset mid-WAIT: assert reset 5 cycles after log_start.
//    Expect all outputs 0 next cycle, no res_valid afterwards, and a new job accepted normally.
//  - Withdraw: req[1] high for one cycle during busy, then low. Expect no ack[1] and no job for id 1.

Source files
------------

// File: rtl/log_scheduler_pkg.sv
// Shared constants for the log core scheduler.
// FSM encodings, default widths and a constant clog2 helper.
package log_scheduler_pkg;

  localparam int W_DEF = 14;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/log_scheduler_rr_pick.sv
// Combinational round-robin picker.
// Lowest offset from ptr (wrapping) wins.
module rr_pick #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] id,
  output logic           any
);

  int             k;
  logic [IDW-1:0] idx;

  always_comb begin
    grant = '0;
    id    = '0;
    any   = |req;
    k     = 0;
    idx   = '0;
    // walk from farthest to nearest so the nearest hit overwrites
    for (int i = N - 1; i >= 0; i--) begin
      k   = (int'(ptr) + i) % N;
      idx = IDW'(k);
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        id         = idx;
      end
    end
  end

endmodule

// File: rtl/log_scheduler.sv
// Round-robin scheduler sharing one iterative log core.
// Owns core timing: start pulse, fixed latency count, result capture.
module log_scheduler
  import log_scheduler_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int W           = W_DEF,
  parameter int LOG_LATENCY = 12,
  parameter int IDW         = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] req_x,
  output logic [N_REQ-1:0]   ack,
  output logic               res_valid,
  output logic [IDW-1:0]     res_id,
  output logic [W-1:0]       res_x,
  output logic [W-1:0]       res_y,
  output logic               res_err,
  output logic               busy,
  output logic [W-1:0]       log_x0,
  output logic               log_start,
  input  logic [W-1:0]       log_xf,
  input  logic [W-1:0]       log_yf
);

  localparam int CW0 = clog2(LOG_LATENCY);
  localparam int CW  = (CW0 < 1) ? 1 : CW0;

  logic [1:0]       state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   gid_q, gid_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic             res_valid_q, res_valid_d;
  logic [IDW-1:0]   res_id_q, res_id_d;
  logic [W-1:0]     res_x_q, res_x_d;
  logic [W-1:0]     res_y_q, res_y_d;
  logic             res_err_q, res_err_d;
  logic             busy_q, busy_d;
  logic [W-1:0]     log_x0_q, log_x0_d;
  logic             log_start_q, log_start_d;

  logic [N_REQ-1:0] pick_oh;
  logic [IDW-1:0]   pick_id;
  logic             pick_any;
  logic [W-1:0]     pick_x;

  rr_pick #(
    .N   (N_REQ),
    .IDW (IDW)
  ) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .grant (pick_oh),
    .id    (pick_id),
    .any   (pick_any)
  );

  assign pick_x = req_x[pick_id*W +: W];

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gid_d       = gid_q;
    cnt_d       = cnt_q;
    ack_d       = '0;
    res_valid_d = 1'b0;
    res_id_d    = res_id_q;
    res_x_d     = res_x_q;
    res_y_d     = res_y_q;
    res_err_d   = 1'b0;
    log_x0_d    = log_x0_q;
    log_start_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (pick_any) begin
          gid_d = pick_id;
          ack_d = pick_oh;
          if (pick_x != '0) begin
            state_d     = S_LAUNCH;
            log_start_d = 1'b1;
            log_x0_d    = pick_x;
          end else begin
            // zero operand: answer directly, core untouched
            state_d     = S_DONE;
            res_valid_d = 1'b1;
            res_err_d   = 1'b1;
            res_id_d    = pick_id;
            res_x_d     = '0;
            res_y_d     = '0;
          end
        end
      end
      S_LAUNCH: begin
        cnt_d   = CW'(LOG_LATENCY - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d     = S_DONE;
          res_valid_d = 1'b1;
          res_id_d    = gid_q;
          res_x_d     = log_xf;
          res_y_d     = log_yf;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        ptr_d   = (gid_q == IDW'(N_REQ - 1)) ? '0 : gid_q + 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      gid_q       <= '0;
      cnt_q       <= '0;
      ack_q       <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_x_q     <= '0;
      res_y_q     <= '0;
      res_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      log_x0_q    <= '0;
      log_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gid_q       <= gid_d;
      cnt_q       <= cnt_d;
      ack_q       <= ack_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_x_q     <= res_x_d;
      res_y_q     <= res_y_d;
      res_err_q   <= res_err_d;
      busy_q      <= busy_d;
      log_x0_q    <= log_x0_d;
      log_start_q <= log_start_d;
    end
  end

  assign ack       = ack_q;
  assign res_valid = res_valid_q;
  assign res_id    = res_id_q;
  assign res_x     = res_x_q;
  assign res_y     = res_y_q;
  assign res_err   = res_err_q;
  assign busy      = busy_q;
  assign log_x0    = log_x0_q;
  assign log_start = log_start_q;

endmodule

// File: tb/tb_log_scheduler.sv
// Scoreboard bench for log_scheduler with a fixed-latency stub core.
// Round-robin reference model predicts grant order and results.
module tb_log_scheduler;

  localparam int N   = 4;
  localparam int W   = 14;
  localparam int LAT = 12;

  logic          clk = 0;
  logic          reset = 1;
  logic [N-1:0]  req = '0;
  logic [N*W-1:0] req_x = '0;
  logic [N-1:0]  ack;
  logic          res_valid;
  logic [1:0]    res_id;
  logic [W-1:0]  res_x, res_y;
  logic          res_err, busy;
  logic [W-1:0]  log_x0;
  logic          log_start;
  logic [W-1:0]  log_xf, log_yf;

  log_scheduler dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_x     (req_x),
    .ack       (ack),
    .res_valid (res_valid),
    .res_id    (res_id),
    .res_x     (res_x),
    .res_y     (res_y),
    .res_err   (res_err),
    .busy      (busy),
    .log_x0    (log_x0),
    .log_start (log_start),
    .log_xf    (log_xf),
    .log_yf    (log_yf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // stub core: outputs are correct only in the exact cycle LAT after start
  logic [W-1:0] stub_x = '0;
  int           stub_cnt = 0;
  always @(posedge clk) begin
    if (reset) stub_cnt <= 0;
    else if (log_start) begin
      stub_x   <= log_x0;
      stub_cnt <= 1;
    end else if (stub_cnt != 0 && stub_cnt < 100) stub_cnt <= stub_cnt + 1;
  end
  assign log_yf = (stub_cnt == LAT) ? (stub_x ^ 14'h3FFF) : 14'h1555;
  assign log_xf = (stub_cnt == LAT) ? 14'h0200 : 14'h0AAA;

  typedef struct {
    int           id;
    logic [W-1:0] x;
    logic [W-1:0] y;
    bit           err;
  } exp_t;

  exp_t         res_exp[$];
  int           ack_exp[$];
  logic [W-1:0] start_exp[$];
  int           start_cyc[$];
  int           ack_cyc[N];
  int           tests = 0;
  int           fails = 0;
  int           got = 0;
  int           raise_cyc = 0;
  bit           first_ack = 0;
  int           ptr_m = 0;

  function automatic void chk(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endfunction

  // monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (ack != '0) begin
        chk("ack_onehot", $countones(ack), 1);
        if (ack_exp.size() == 0) chk("ack_unexpected", int'(ack), 0);
        else begin
          int e;
          e = ack_exp.pop_front();
          chk("ack_id", int'(ack), 1 << e);
          ack_cyc[e] = cyc;
        end
        if (first_ack) begin
          chk("ack_latency", cyc - raise_cyc, 1);
          first_ack = 0;
        end
      end
      if (log_start) begin
        start_cyc.push_back(cyc);
        if (start_exp.size() == 0) chk("start_unexpected", 1, 0);
        else chk("log_x0", int'(log_x0), int'(start_exp.pop_front()));
      end
      if (res_valid) begin
        if (res_exp.size() == 0) chk("res_unexpected", 1, 0);
        else begin
          exp_t e;
          e = res_exp.pop_front();
          chk("res_id", int'(res_id), e.id);
          chk("res_x", int'(res_x), int'(e.x));
          chk("res_y", int'(res_y), int'(e.y));
          chk("res_err", int'(res_err), int'(e.err));
          chk("res_latency", cyc - ack_cyc[e.id], e.err ? 0 : LAT + 1);
          chk("busy_in_done", int'(busy), 1);
        end
        got++;
      end
    end
  end

  task automatic run_round(input logic [N-1:0] mask,
                           input logic [N*W-1:0] xs,
                           input int pulse_id);
    int n, last, target, budget;
    n    = 0;
    last = ptr_m;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (ptr_m + k) % N;
      if (mask[i]) begin
        logic [W-1:0] x;
        x = xs[i*W +: W];
        ack_exp.push_back(i);
        if (x == '0) res_exp.push_back('{i, '0, '0, 1'b1});
        else begin
          start_exp.push_back(x);
          res_exp.push_back('{i, 14'h0200, x ^ 14'h3FFF, 1'b0});
        end
        last = i;
        n++;
      end
    end
    ptr_m     = (last + 1) % N;
    target    = got + n;
    budget    = n * (LAT + 3) + 10;
    req_x     = xs;
    req       = mask;
    raise_cyc = cyc;
    first_ack = 1;
    for (int t = 0; t < budget && got < target; t++) begin
      @(negedge clk);
      req = req & ~ack;
      if (pulse_id >= 0 && t == 3) req[pulse_id] = 1'b1;
      if (pulse_id >= 0 && t == 4) req[pulse_id] = 1'b0;
    end
    if (got < target) begin
      chk("round_timeout", got, target);
      res_exp.delete();
      ack_exp.delete();
      start_exp.delete();
      got = target;
    end
    req = '0;
    @(negedge clk);
  endtask

  task automatic chk_outs_zero(string name);
    chk(name, int'(|{ack, res_valid, res_id, res_x, res_y, res_err,
                     busy, log_x0, log_start}), 0);
  endtask

  initial begin
    logic [N*W-1:0] xs;
    bit seen;
    reset = 1;
    repeat (3) @(negedge clk);
    chk_outs_zero("reset_outputs");
    reset = 0;
    @(negedge clk);

    // contention: 1111 from ptr 0, four starts 15 cycles apart
    start_cyc.delete();
    run_round(4'b1111, {14'h0444, 14'h0333, 14'h0222, 14'h0111}, -1);
    chk("contention_starts", start_cyc.size(), 4);
    for (int i = 1; i < start_cyc.size(); i++)
      chk("start_spacing", start_cyc[i] - start_cyc[i-1], LAT + 3);

    // single job
    run_round(4'b0001, {14'h0, 14'h0, 14'h0, 14'h02E0}, -1);
    // fairness: serve 1, then 1001 must grant 3 before 0
    run_round(4'b0010, {14'h0, 14'h0, 14'h0123, 14'h0}, -1);
    run_round(4'b1001, {14'h0FED, 14'h0, 14'h0, 14'h0ABC}, -1);
    // zero operand
    start_cyc.delete();
    run_round(4'b0100, {14'h0, 14'h0, 14'h0, 14'h0}, -1);
    chk("zero_no_start", start_cyc.size(), 0);
    // withdraw: req[1] pulses while busy
    run_round(4'b0001, {14'h0, 14'h0, 14'h1FFF, 14'h0777}, 1);

    // reset mid-WAIT
    ack_exp.push_back(ptr_m);
    start_exp.push_back(14'h0155);
    xs = '0;
    xs[ptr_m*W +: W] = 14'h0155;
    req_x = xs;
    req = '0;
    req[ptr_m] = 1'b1;
    first_ack = 0;
    seen = 0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      req = req & ~ack;
      if (log_start) seen = 1;
    end
    chk("rst_start_seen", int'(seen), 1);
    req = '0;
    repeat (5) @(negedge clk);
    reset = 1;
    @(negedge clk);
    chk_outs_zero("reset_midwait_outputs");
    reset = 0;
    ptr_m = 0;
    start_exp.delete();
    ack_exp.delete();
    repeat (25) @(negedge clk);
    run_round(4'b0100, {14'h0, 14'h2001, 14'h0, 14'h0}, -1);

    // randomized rounds
    for (int r = 0; r < 30; r++) begin
      logic [N-1:0] m;
      m = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++)
        xs[i*W +: W] = ($urandom_range(0, 4) == 0) ? 14'h0
                       : W'($urandom_range(1, 16383));
      run_round(m, xs, -1);
    end
    chk("queues_drained", res_exp.size() + ack_exp.size() + start_exp.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
